// File: rtl/vproc_vreg_wrbuf.sv
// Write buffer for one vector register file write port: queues result writes,
// merges back-to-back writes to the same address and flags pending vreg writes.
module vproc_vreg_wrbuf #(
    parameter int unsigned MAX_PORT_W = 128,
    parameter int unsigned MAX_ADDR_W = 5,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      clk_i,
    input  logic                      async_rst_ni,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [MAX_ADDR_W-1:0]     in_addr_i,
    input  logic [MAX_PORT_W-1:0]     in_data_i,
    input  logic [MAX_PORT_W/8-1:0]   in_be_i,
    output logic                      wr_we_o,
    input  logic                      wr_gnt_i,
    output logic [MAX_ADDR_W-1:0]     wr_addr_o,
    output logic [MAX_PORT_W-1:0]     wr_data_o,
    output logic [MAX_PORT_W/8-1:0]   wr_be_o,
    input  logic [4:0]                pend_vreg_i,
    output logic                      pend_hit_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = MAX_PORT_W / 8;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [MAX_ADDR_W-1:0] r_addr [DEPTH];
    logic [MAX_PORT_W-1:0] r_data [DEPTH];
    logic [BW-1:0]         r_be   [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic [PW-1:0]         w_young;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_merge;
    logic                  w_alloc;
    logic [MAX_PORT_W-1:0] w_merged_data;
    logic [DEPTH-1:0]      w_valid;
    logic [DEPTH-1:0]      w_hit;

    assign in_ready_o = (r_count != FULL);
    assign wr_we_o    = (r_count != '0);
    assign count_o    = r_count;

    assign w_young = r_tail - PW'(1);
    assign w_push  = in_valid_i & in_ready_o & ~flush_i;
    assign w_pop   = wr_we_o & wr_gnt_i & ~flush_i;
    // The youngest entry is only mergeable when it cannot be the departing head.
    assign w_merge = w_push && (r_count >= CW'(2)) && (in_addr_i == r_addr[w_young]);
    assign w_alloc = w_push & ~w_merge;

    generate
        for (genvar gi = 0; gi < BW; gi++) begin : g_merge
            assign w_merged_data[gi*8 +: 8] = in_be_i[gi] ? in_data_i[gi*8 +: 8]
                                                          : r_data[w_young][gi*8 +: 8];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
            logic [PW-1:0] w_off;
            assign w_off       = PW'(gi) - r_head;
            assign w_valid[gi] = ({1'b0, w_off} < r_count);
            assign w_hit[gi]   = w_valid[gi] && (r_addr[gi][MAX_ADDR_W-1 -: 5] == pend_vreg_i);
        end
    endgenerate

    assign pend_hit_o = |w_hit;

    // Empty buffer presents all-zero fields regardless of stale storage.
    assign wr_addr_o = wr_we_o ? r_addr[r_head] : '0;
    assign wr_data_o = wr_we_o ? r_data[r_head] : '0;
    assign wr_be_o   = wr_we_o ? r_be[r_head]   : '0;

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_alloc) begin
            r_addr[r_tail] <= in_addr_i;
            r_data[r_tail] <= in_data_i;
            r_be[r_tail]   <= in_be_i;
        end else if (w_merge) begin
            r_data[w_young] <= w_merged_data;
            r_be[w_young]   <= r_be[w_young] | in_be_i;
        end
    end
endmodule
